// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter                                                            |
// | Round-robin arbiter that shares one UART_TX between NUM_REQ producers.     |
// | Optional busy-rise timeout with err pulse: define UART_ARB_TIMEOUT_EN.     |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int WIDTH        = 8,
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 2,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     tx_busy,
  output logic                     tx_data_valid,
  output logic [WIDTH-1:0]         tx_p_data,
  output logic [IDX_W-1:0]         gnt_id,
  output logic                     arb_busy,
  output logic                     err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam logic [IDX_W:0]   C_NUM     = NUM_REQ[IDX_W:0];
  localparam logic [IDX_W:0]   C_LAST    = C_NUM - 1'b1;
  localparam logic [NUM_REQ-1:0] C_ONE   = NUM_REQ'(1);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (IDX_W != $clog2(NUM_REQ)) begin : g_bad_idx_w
      $error("uart_tx_arbiter: IDX_W must equal clog2(NUM_REQ)");
    end
    if (BUSY_TIMEOUT < 1) begin : g_bad_timeout
      $error("uart_tx_arbiter: BUSY_TIMEOUT must be at least 1");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W:0]     w_cand [NUM_REQ];
  logic [NUM_REQ-1:0] w_hit;
  logic [WIDTH-1:0]   w_lane [NUM_REQ];
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_tmo_hit;

  // Candidate k is the requester k places after rr_ptr, wrapped modulo NUM_REQ.
  genvar gk;
  generate
    for (gk = 0; gk < NUM_REQ; gk++) begin : g_cand
      localparam logic [IDX_W:0] C_OFS = (IDX_W+1)'(gk);
      logic [IDX_W:0] w_sum;
      assign w_sum      = {1'b0, r_rr_ptr} + C_OFS;
      assign w_cand[gk] = (w_sum >= C_NUM) ? (w_sum - C_NUM) : w_sum;
      assign w_hit[gk]  = req[w_cand[gk][IDX_W-1:0]];
      assign w_lane[gk] = req_data[gk*WIDTH +: WIDTH];
    end
  endgenerate

  // Walk downward so the candidate closest to rr_ptr wins.
  always_comb begin
    w_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_pick = w_cand[k][IDX_W-1:0];
      end
    end
  end

  assign w_found    = |w_hit;
  assign w_next_ptr = ({1'b0, gnt_id} == C_LAST) ? '0 : gnt_id + 1'b1;
  assign arb_busy   = (r_state != ST_IDLE);

  // A grant is held off during the ack cycle so the served producer can drop req.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      ack           <= '0;
      tx_data_valid <= 1'b0;
      tx_p_data     <= '0;
      gnt_id        <= '0;
    end else begin
      ack           <= '0;
      tx_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && (ack == '0)) begin
            gnt_id        <= w_pick;
            tx_p_data     <= w_lane[w_pick];
            tx_data_valid <= 1'b1;
            r_state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (w_tmo_hit) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            ack      <= C_ONE << gnt_id;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_tmo_hit = (r_state == ST_WAIT_BUSY) && !tx_busy && (r_tmo_cnt == C_TMO_LAST);
  assign err       = r_err;

  // Counter is held at zero outside WAIT_BUSY, so every entry starts fresh.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_tmo_hit;
      if ((r_state != ST_WAIT_BUSY) || w_tmo_hit) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
`default_nettype wire
